// File: rtl/bsg_link_loopback_traffic_node.sv
// Loopback traffic node: drives a deterministic packet stream on the
// outgoing ready/valid link and checks the looped-back incoming stream.
// Ports: clk_i/reset_i (sync, active-high); en_i, mode_i, gap_i control;
// v_o/data_o/ready_and_i outgoing; v_i/data_i/ready_and_o incoming;
// done_o, error_o, timeout_o, sent_o, received_o, first_err_idx_o status.
module bsg_link_loopback_traffic_node #(
  parameter int          width_p           = 32,
  parameter int          max_outstanding_p = 16,
  parameter int          timeout_p         = 4096,
  parameter logic [31:0] seed_p            = 32'h1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               mode_i,
  input  logic [3:0]         gap_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_and_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_and_o,
  output logic               done_o,
  output logic               error_o,
  output logic               timeout_o,
  output logic [31:0]        sent_o,
  output logic [31:0]        received_o,
  output logic [31:0]        first_err_idx_o
);

  localparam int OW  = $clog2(max_outstanding_p + 1);
  localparam int DW0 = $clog2(timeout_p + 1);
  localparam int DW  = (DW0 < 16) ? 16 : ((DW0 > 32) ? 32 : DW0);
  localparam int REP = (width_p + 31) / 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // x^32 + x^22 + x^2 + x + 1, shifting toward the MSB
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [width_p-1:0] pat(
    input logic               m,
    input logic [width_p-1:0] c,
    input logic [31:0]        l
  );
    logic [REP*32-1:0] r;
    r = {REP{l}};
    return m ? r[width_p-1:0] : c;
  endfunction

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [3:0]         gap_q, gap_d;
  logic [OW-1:0]      outs_q, outs_d;
  logic [width_p-1:0] tx_cnt_q, tx_cnt_d;
  logic [width_p-1:0] rx_cnt_q, rx_cnt_d;
  logic [31:0]        tx_lfsr_q, tx_lfsr_d;
  logic [31:0]        rx_lfsr_q, rx_lfsr_d;
  logic [31:0]        sent_q, sent_d;
  logic [31:0]        recv_q, recv_d;
  logic [31:0]        ferr_q, ferr_d;
  logic               err_q, err_d;
  logic               tmo_q, tmo_d;
  logic [DW-1:0]      drain_q, drain_d;

  logic               tx_fire, rx_fire, unexp, rx_ok, mism;
  logic [width_p-1:0] rx_pat;

  assign v_o = (state_q == RUN) && (gap_q == 4'd0)
            && (outs_q < OW'(max_outstanding_p));
  assign data_o      = pat(mode_q, tx_cnt_q, tx_lfsr_q);
  assign ready_and_o = (state_q == RUN) || (state_q == DRAIN);
  assign rx_pat      = pat(mode_q, rx_cnt_q, rx_lfsr_q);

  assign tx_fire = v_o & ready_and_i;
  assign rx_fire = v_i & ready_and_o;
  // a receive with nothing in flight is bogus unless it is the
  // same-cycle echo of this cycle's send
  assign unexp = rx_fire & (outs_q == '0) & ~tx_fire;
  assign rx_ok = rx_fire & ~unexp;
  assign mism  = rx_ok & (data_i != rx_pat);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    gap_d     = gap_q;
    outs_d    = outs_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    tx_lfsr_d = tx_lfsr_q;
    rx_lfsr_d = rx_lfsr_q;
    sent_d    = sent_q;
    recv_d    = recv_q;
    ferr_d    = ferr_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    drain_d   = drain_q;

    if (tx_fire) begin
      tx_cnt_d  = tx_cnt_q + 1'b1;
      tx_lfsr_d = lfsr_next(tx_lfsr_q);
      sent_d    = (sent_q == '1) ? sent_q : sent_q + 32'd1;
      gap_d     = gap_i;
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end

    if (rx_ok) begin
      rx_cnt_d  = rx_cnt_q + 1'b1;
      rx_lfsr_d = lfsr_next(rx_lfsr_q);
      recv_d    = (recv_q == '1) ? recv_q : recv_q + 32'd1;
    end

    unique case ({tx_fire, rx_ok})
      2'b10:   outs_d = outs_q + 1'b1;
      2'b01:   outs_d = outs_q - 1'b1;
      default: outs_d = outs_q;
    endcase

    if ((unexp | mism) & ~err_q) begin
      ferr_d = recv_q;
    end
    err_d = err_q | unexp | mism;

    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = RUN;
          mode_d  = mode_i;
        end
      end
      RUN: begin
        if (!en_i) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (outs_q == '0) begin
          state_d = DONE;
        end else if (drain_q == DW'(timeout_p - 1)) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      gap_q     <= '0;
      outs_q    <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      tx_lfsr_q <= seed_p;
      rx_lfsr_q <= seed_p;
      sent_q    <= '0;
      recv_q    <= '0;
      ferr_q    <= '0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      gap_q     <= gap_d;
      outs_q    <= outs_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_lfsr_q <= tx_lfsr_d;
      rx_lfsr_q <= rx_lfsr_d;
      sent_q    <= sent_d;
      recv_q    <= recv_d;
      ferr_q    <= ferr_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      drain_q   <= drain_d;
    end
  end

  assign done_o          = (state_q == DONE);
  assign error_o         = err_q;
  assign timeout_o       = tmo_q;
  assign sent_o          = sent_q;
  assign received_o      = recv_q;
  assign first_err_idx_o = ferr_q;

endmodule

// File: tb/tb_bsg_link_loopback_traffic_node.sv
// Testbench for bsg_link_loopback_traffic_node: loopback channel model,
// tx scoreboard against a reference pattern model, status checks.
module tb_bsg_link_loopback_traffic_node;

  localparam int          W    = 64;
  localparam int          MO   = 4;
  localparam int          TO   = 64;
  localparam logic [31:0] SEED = 32'h1;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          en_i = 1'b0;
  logic          mode_i = 1'b0;
  logic [3:0]    gap_i = 4'd0;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic          ready_and_i = 1'b1;
  logic          v_i;
  logic [W-1:0]  data_i;
  logic          ready_and_o;
  logic          done_o, error_o, timeout_o;
  logic [31:0]   sent_o, received_o, first_err_idx_o;

  always #5 clk = ~clk;

  bsg_link_loopback_traffic_node #(
    .width_p(W), .max_outstanding_p(MO),
    .timeout_p(TO), .seed_p(SEED)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i),
    .mode_i(mode_i), .gap_i(gap_i),
    .v_o(v_o), .data_o(data_o), .ready_and_i(ready_and_i),
    .v_i(v_i), .data_i(data_i), .ready_and_o(ready_and_o),
    .done_o(done_o), .error_o(error_o), .timeout_o(timeout_o),
    .sent_o(sent_o), .received_o(received_o),
    .first_err_idx_o(first_err_idx_o)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // channel model controls
  int           lat = 0;
  int           drop_idx = -1;
  int           corr_idx = -1;
  logic         inj = 1'b0;
  logic         stall_chk = 1'b0;
  logic         gap_chk = 1'b0;
  logic [W-1:0] cmask = 64'h8;

  typedef struct {
    logic [W-1:0] d;
    int           due;
    int           idx;
  } pkt_t;

  pkt_t         chq[$];
  logic [W-1:0] exp_q[$];
  int           cyc = 0;
  int           txn = 0;
  int           rxn = 0;
  int           last_tx = -1;
  logic         ch_v = 1'b0;
  logic [W-1:0] ch_d = '0;
  int           ch_idx = -1;

  assign v_i = ((lat == 0) ? (v_o & ready_and_i & (txn != drop_idx))
                           : ch_v) | inj;
  assign data_i = (lat == 0)
    ? (data_o ^ ((txn == corr_idx) ? cmask : '0)) : ch_d;

  // reference pattern: counter k, or the LFSR state after k steps
  // of the x^32+x^22+x^2+x+1 recurrence, replicated to 64 bits
  function automatic logic [31:0] poly_step(input logic [31:0] s);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return (s << 1) | {31'd0, fb};
  endfunction

  task automatic fill_model(input logic m, input int n);
    logic [31:0] s;
    s = SEED;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      if (m) exp_q.push_back({s, s});
      else   exp_q.push_back(W'(k));
      s = poly_step(s);
    end
  endtask

  // monitor, scoreboard and delay channel
  always begin : mon
    logic         txf, rxf, rxv, unexp, prev_stall;
    logic [W-1:0] txd, prev_d;
    int           tidx;
    prev_stall = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge clk);
      txf   = v_o & ready_and_i & ~reset_i;
      rxf   = v_i & ready_and_o & ~reset_i;
      unexp = rxf && (txn == rxn) && !txf;
      rxv   = rxf && !unexp;
      txd   = data_o;
      tidx  = txn;
      if (!reset_i && v_o)
        chk("credit", 64'((txn - rxn) < MO), 64'd1);
      if (stall_chk && prev_stall) begin
        chk("stall_v", 64'(v_o), 64'd1);
        chk("stall_data", data_o, prev_d);
      end
      prev_stall = v_o & ~ready_and_i;
      prev_d = data_o;
      if (!gap_chk) last_tx = -1;
      if (txf) begin
        if (exp_q.size() == 0) begin
          chk("tx_underrun", 64'd0, 64'd1);
        end else begin
          chk("tx_data", data_o, exp_q.pop_front());
        end
        if (gap_chk && last_tx >= 0)
          chk("gap", 64'(cyc - last_tx), 64'd4);
        last_tx = cyc;
      end
      @(posedge clk);
      #2;
      if (reset_i) begin
        chq.delete();
        txn = 0;
        rxn = 0;
        prev_stall = 1'b0;
      end else begin
        if (txf) begin
          if (lat > 0 && tidx != drop_idx)
            chq.push_back('{d: txd ^ ((tidx == corr_idx) ? cmask : '0),
                            due: cyc + lat, idx: tidx});
          txn++;
        end
        if (rxv) begin
          rxn++;
          if (lat > 0 && chq.size() > 0) void'(chq.pop_front());
        end
      end
      cyc++;
      if (chq.size() > 0 && chq[0].due <= cyc) begin
        ch_v = 1'b1;
        ch_d = chq[0].d;
        ch_idx = chq[0].idx;
      end else begin
        ch_v = 1'b0;
        ch_idx = -1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input int dr, input int co);
    step(1);
    reset_i = 1'b1;
    en_i = 1'b0;
    ready_and_i = 1'b1;
    gap_i = 4'd0;
    inj = 1'b0;
    stall_chk = 1'b0;
    gap_chk = 1'b0;
    lat = l;
    drop_idx = dr;
    corr_idx = co;
    step(2);
    exp_q.delete();
    reset_i = 1'b0;
  endtask

  task automatic start(input logic m);
    fill_model(m, 1500);
    mode_i = m;
    en_i = 1'b1;
  endtask

  task automatic wait_done(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_o) break;
    end
    chk(nm, 64'(done_o), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v"}, 64'(v_o), 64'd0);
    chk({tag, "_data"}, data_o, 64'd0);
    chk({tag, "_rdy"}, 64'(ready_and_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_err"}, 64'(error_o), 64'd0);
    chk({tag, "_tmo"}, 64'(timeout_o), 64'd0);
    chk({tag, "_sent"}, 64'(sent_o), 64'd0);
    chk({tag, "_recv"}, 64'(received_o), 64'd0);
    chk({tag, "_ferr"}, 64'(first_err_idx_o), 64'd0);
  endtask

  initial begin : wdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n0, k;

    // reset state
    do_reset(0, -1, -1);
    @(negedge clk);
    chk_zero("reset");

    // direct loopback, counter mode, 100 cycles of enable
    do_reset(0, -1, -1);
    start(1'b0);
    step(100);
    en_i = 1'b0;
    step(2);
    chk("direct_done", 64'(done_o), 64'd1);
    chk("direct_sent", 64'(sent_o), 64'd100);
    chk("direct_recv", 64'(received_o), 64'd100);
    chk("direct_err", 64'(error_o), 64'd0);
    chk("direct_tmo", 64'(timeout_o), 64'd0);

    // LFSR mode, random backpressure, 1000 packets
    do_reset(2, -1, -1);
    start(1'b1);
    for (int i = 0; i < 20000 && txn < 1000; i++) begin
      step(1);
      ready_and_i = ($urandom_range(0, 3) != 0);
    end
    chk("lfsr_budget", 64'(txn >= 1000), 64'd1);
    ready_and_i = 1'b1;
    en_i = 1'b0;
    wait_done("lfsr_done", 200);
    chk("lfsr_err", 64'(error_o), 64'd0);
    chk("lfsr_tmo", 64'(timeout_o), 64'd0);
    chk("lfsr_sent", 64'(sent_o), 64'(txn));
    chk("lfsr_recv", 64'(received_o), 64'(txn));

    // credit limit through a long loop: 4 packets per 8 cycles
    do_reset(7, -1, -1);
    start(1'b0);
    step(40);
    @(negedge clk);
    n0 = txn;
    repeat (80) @(negedge clk);
    chk("thruput", 64'(txn - n0), 64'd40);
    step(1);
    en_i = 1'b0;
    wait_done("credit_done", 200);
    chk("credit_err", 64'(error_o), 64'd0);
    chk("credit_tmo", 64'(timeout_o), 64'd0);

    // corrupt bit 3 of packet 5
    do_reset(1, -1, 5);
    start(1'b0);
    k = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (v_i && ready_and_o && ch_idx == 5) begin
        k = 1;
        break;
      end
    end
    chk("corr_seen", 64'(k), 64'd1);
    chk("corr_err_pre", 64'(error_o), 64'd0);
    @(negedge clk);
    chk("corr_err", 64'(error_o), 64'd1);
    chk("corr_ferr", 64'(first_err_idx_o), 64'd5);
    for (int i = 0; i < 400 && txn < 40; i++) step(1);
    @(negedge clk);
    chk("corr_sticky", 64'(error_o), 64'd1);
    chk("corr_ferr2", 64'(first_err_idx_o), 64'd5);
    chk("corr_recv", 64'(received_o), 64'(rxn));

    // drop packet 7, drain must time out
    do_reset(2, 7, -1);
    start(1'b0);
    for (int i = 0; i < 400 && txn < 20; i++) step(1);
    en_i = 1'b0;
    k = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done_o) break;
      k++;
    end
    chk("drop_drain_len", 64'(k), 64'(TO + 1));
    chk("drop_tmo", 64'(timeout_o), 64'd1);
    chk("drop_gap", 64'(sent_o - received_o), 64'd1);
    chk("drop_err", 64'(error_o), 64'd1);
    chk("drop_ferr", 64'(first_err_idx_o), 64'd7);

    // gap 3, 20-cycle stall, reset mid-run
    do_reset(1, -1, -1);
    gap_i = 4'd3;
    gap_chk = 1'b1;
    start(1'b0);
    step(30);
    gap_chk = 1'b0;
    stall_chk = 1'b1;
    ready_and_i = 1'b0;
    step(20);
    @(negedge clk);
    chk("stall_hold", 64'(v_o), 64'd1);
    step(1);
    ready_and_i = 1'b1;
    step(2);
    stall_chk = 1'b0;
    gap_chk = 1'b1;
    step(30);
    gap_chk = 1'b0;
    reset_i = 1'b1;
    step(1);
    @(negedge clk);
    chk_zero("midreset");
    step(1);
    exp_q.delete();
    en_i = 1'b0;
    reset_i = 1'b0;

    // unexpected packet with nothing outstanding
    do_reset(1, -1, -1);
    ready_and_i = 1'b0;
    start(1'b0);
    step(3);
    inj = 1'b1;
    step(1);
    inj = 1'b0;
    @(negedge clk);
    chk("unexp_err", 64'(error_o), 64'd1);
    chk("unexp_recv", 64'(received_o), 64'd0);
    chk("unexp_ferr", 64'(first_err_idx_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
